// File: rtl/add_serial_pkg.sv
// add_serial_pkg: shared types and sizing helpers for the slice-serial adder.
package add_serial_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_SLICE_W = 4;
    localparam int NUM_SLICES  = DEF_WIDTH / DEF_SLICE_W;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// add_slice: combinational SLICE_W-bit adder with carry in and carry out.
module add_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/add_8bit_serial.sv
// add_8bit_serial: unsigned M_i + N_i computed one slice per clock through a
// single slice adder and a registered carry, with valid/ready on both sides.
module add_8bit_serial
    import add_serial_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SLICE_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] M_i,
    input  logic [WIDTH-1:0] N_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   result_o
);

    localparam int NS = WIDTH / SLICE_W;
    localparam int CW = cnt_w(NS);

    state_t                        state_q;
    logic [CW-1:0]                 idx_q;
    logic                          carry_q;
    logic                          cout_q;
    logic                          ready_q;
    logic                          valid_q;
    logic [NS-1:0][SLICE_W-1:0]    m_q;
    logic [NS-1:0][SLICE_W-1:0]    n_q;
    logic [NS-1:0][SLICE_W-1:0]    sum_q;
    logic [SLICE_W-1:0]            slice_sum;
    logic                          slice_cout;
    logic                          last;

    add_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a    (m_q[idx_q]),
        .b    (n_q[idx_q]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign last     = idx_q == CW'(NS - 1);
    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = {cout_q, sum_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            m_q     <= '0;
            n_q     <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (valid_i) begin
                    m_q     <= M_i;
                    n_q     <= N_i;
                    carry_q <= 1'b0;
                    idx_q   <= '0;
                    ready_q <= 1'b0;
                    state_q <= CALC;
                end
                CALC: begin
                    sum_q[idx_q] <= slice_sum;
                    carry_q      <= slice_cout;
                    idx_q        <= idx_q + 1'b1;
                    if (last) begin
                        cout_q  <= slice_cout;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: if (ready_i) begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
